// File: rtl/scumv_stl_pkg.sv
// Shared STL path definitions: bridge state encoding and packet geometry
// common to the UART protocol handler and the packet bridge.
package scumv_stl_pkg;

    typedef enum logic [1:0] {
        ST_COLLECT  = 2'd0,
        ST_ISSUE    = 2'd1,
        ST_WAIT_RSP = 2'd2,
        ST_SEND     = 2'd3
    } stl_state_e;

    localparam int         STL_PKT_BYTES    = 16;
    localparam int         STL_RESP_BYTES   = 16;
    localparam logic [7:0] STL_TIMEOUT_BYTE = 8'hEE;

endpackage

// File: rtl/stl_resp_serializer.sv
// Response word to byte stream: loads a full word, then shifts it out LSB
// byte first under valid/ready, pulsing done on the last accepted byte.
module stl_resp_serializer import scumv_stl_pkg::*; #(
    parameter int BYTES = STL_RESP_BYTES
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic [8*BYTES-1:0]   load_data,
    output logic                 valid,
    input  logic                 ready,
    output logic [7:0]           data,
    output logic                 done
);

    localparam int             IW       = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [IW-1:0]  IDX_LAST = IW'(BYTES - 1);

    logic [8*BYTES-1:0] shreg_q;
    logic [IW-1:0]      idx;
    logic               active;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shreg_q <= '0;
            idx     <= '0;
            active  <= 1'b0;
        end else if (load) begin
            shreg_q <= load_data;
            idx     <= '0;
            active  <= 1'b1;
        end else if (active && ready) begin
            shreg_q <= {8'h00, shreg_q[8*BYTES-1:8]};
            if (idx == IDX_LAST) begin
                idx    <= '0;
                active <= 1'b0;
            end else begin
                idx <= idx + IW'(1);
            end
        end
    end

    assign valid = active;
    assign data  = shreg_q[7:0];
    assign done  = active && ready && (idx == IDX_LAST);

endmodule

// File: rtl/stl_packet_bridge.sv
// STL byte-to-packet bridge: assembles request bytes into one wide request,
// returns the response as bytes. Optional watchdog: STL_BRIDGE_TIMEOUT_EN.
module stl_packet_bridge import scumv_stl_pkg::*; #(
    parameter int         PKT_BYTES      = STL_PKT_BYTES,
    parameter int         RESP_BYTES     = STL_RESP_BYTES,
    parameter int         TIMEOUT_CYCLES = 1_000_000,
    parameter logic [7:0] TIMEOUT_BYTE   = STL_TIMEOUT_BYTE
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [7:0]              in_data,
    output logic                    req_valid,
    input  logic                    req_ready,
    output logic [8*PKT_BYTES-1:0]  req_bits,
    input  logic                    rsp_valid,
    output logic                    rsp_ready,
    input  logic [8*RESP_BYTES-1:0] rsp_bits,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [7:0]              resp_data,
    output logic                    busy,
    output logic [7:0]              timeout_count,
    output logic [1:0]              debug_state
);

    localparam int             CW       = (PKT_BYTES > 1) ? $clog2(PKT_BYTES) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(PKT_BYTES - 1);

    stl_state_e               state, state_nxt;
    logic [CW-1:0]            byte_cnt;
    logic [8*PKT_BYTES-1:0]   req_q;
    logic [8*RESP_BYTES-1:0]  ser_data;
    logic                     byte_acc, rsp_acc, expire, ser_load, ser_done;

    assign byte_acc = in_valid && in_ready;
    assign rsp_acc  = rsp_valid && rsp_ready;
    assign ser_load = rsp_acc || expire;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_COLLECT;
        else        state <= state_nxt;
    end

    // Request assembly: byte k lands in lane k, byte 0 least significant
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            byte_cnt <= '0;
            req_q    <= '0;
        end else if (byte_acc) begin
            req_q[8*byte_cnt +: 8] <= in_data;
            byte_cnt <= (byte_cnt == CNT_LAST) ? '0 : byte_cnt + CW'(1);
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        case (state)
            ST_COLLECT: begin
                in_ready = 1'b1;
                if (in_valid && byte_cnt == CNT_LAST) state_nxt = ST_ISSUE;
            end
            ST_ISSUE: begin
                req_valid = 1'b1;
                if (req_ready) state_nxt = ST_WAIT_RSP;
            end
            ST_WAIT_RSP: begin
                rsp_ready = 1'b1;
                if (rsp_valid || expire) state_nxt = ST_SEND;
            end
            ST_SEND: begin
                if (ser_done) state_nxt = ST_COLLECT;
            end
            default: state_nxt = ST_COLLECT;
        endcase
    end

`ifdef STL_BRIDGE_TIMEOUT_EN
    logic [31:0] wd_cnt;
    logic [7:0]  to_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wd_cnt <= '0;
            to_cnt <= '0;
        end else begin
            wd_cnt <= (state == ST_WAIT_RSP) ? wd_cnt + 32'd1 : 32'd0;
            if (expire && to_cnt != 8'hFF) to_cnt <= to_cnt + 8'd1;
        end
    end

    // A real response arriving in the expiry cycle takes precedence
    assign expire        = (state == ST_WAIT_RSP) && !rsp_valid &&
                           (wd_cnt == 32'(TIMEOUT_CYCLES - 1));
    assign ser_data      = expire ? {RESP_BYTES{TIMEOUT_BYTE}} : rsp_bits;
    assign timeout_count = to_cnt;
`else
    logic unused_timeout_cfg;

    assign expire             = 1'b0;
    assign ser_data           = rsp_bits;
    assign timeout_count      = 8'h00;
    assign unused_timeout_cfg = ^{TIMEOUT_CYCLES, TIMEOUT_BYTE};
`endif

    stl_resp_serializer #(.BYTES(RESP_BYTES)) u_resp_ser (
        .clk       (clk),
        .reset     (reset),
        .load      (ser_load),
        .load_data (ser_data),
        .valid     (resp_valid),
        .ready     (resp_ready),
        .data      (resp_data),
        .done      (ser_done)
    );

    assign req_bits    = req_q;
    assign busy        = (state != ST_COLLECT) || (byte_cnt != '0);
    assign debug_state = state;

endmodule

// File: tb/tb_stl_packet_bridge.sv
// Randomized self-checking bench for stl_packet_bridge against a
// transaction-level model of the request/response byte streams.
module tb_stl_packet_bridge;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid, in_ready;
    logic [7:0]   in_data;
    logic         req_valid, req_ready;
    logic [127:0] req_bits;
    logic         rsp_valid, rsp_ready;
    logic [127:0] rsp_bits;
    logic         resp_valid, resp_ready;
    logic [7:0]   resp_data;
    logic         busy;
    logic [7:0]   timeout_count;
    logic [1:0]   debug_state;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    stl_packet_bridge #(.TIMEOUT_CYCLES(100)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .req_valid(req_valid), .req_ready(req_ready), .req_bits(req_bits),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_bits(rsp_bits),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .busy(busy), .timeout_count(timeout_count), .debug_state(debug_state)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_in_ready"},   in_ready, 1);
        chk({tag, "_req_valid"},  req_valid, 0);
        chk({tag, "_rsp_ready"},  rsp_ready, 0);
        chk({tag, "_resp_valid"}, resp_valid, 0);
        chk({tag, "_busy"},       busy, 0);
        chk({tag, "_req_bits"},   req_bits, 0);
        chk({tag, "_resp_data"},  resp_data, 0);
        chk({tag, "_tmo_cnt"},    timeout_count, 0);
        chk({tag, "_state"},      debug_state, 0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Push nbytes bytes of pkt (LSB byte first); optionally check the request.
    task automatic send_bytes(input logic [127:0] pkt, input int nbytes, input int gapmax,
                              input bit check_req);
        int n;
        for (int i = 0; i < nbytes; i++) begin
            if (gapmax > 0) begin
                in_valid = 1'b0;
                repeat ($urandom_range(0, gapmax)) tick();
            end
            in_valid = 1'b1;
            in_data  = pkt[8*i +: 8];
            n = 0;
            @(negedge clk);
            while (!in_ready && n < 100) begin
                @(negedge clk);
                n++;
            end
            if (n >= 100) chk("in_ready_timeout", 0, 1);
            tick();
        end
        in_valid = 1'b0;
        if (check_req) begin
            chk("req_valid_latency", req_valid, 1);
            chk("req_bits", req_bits, pkt);
            chk("in_ready_issue", in_ready, 0);
        end
    endtask

    task automatic issue_ack(input logic [127:0] pkt, input int delay, input bit extra);
        if (extra) begin
            in_valid = 1'b1;
            in_data  = 8'h55;
        end
        for (int i = 0; i < delay; i++) begin
            @(negedge clk);
            chk("req_hold_valid", req_valid, 1);
            chk("req_hold_bits", req_bits, pkt);
            chk("req_hold_in_ready", in_ready, 0);
            tick();
        end
        req_ready = 1'b1;
        tick();
        req_ready = 1'b0;
        chk("wait_state", debug_state, 2);
        chk("wait_rsp_ready", rsp_ready, 1);
        chk("wait_in_ready", in_ready, 0);
        in_valid = 1'b0;
    endtask

    task automatic give_rsp(input logic [127:0] w, input int delay);
        repeat (delay) tick();
        rsp_valid = 1'b1;
        rsp_bits  = w;
        tick();
        rsp_valid = 1'b0;
        chk("resp_valid_latency", resp_valid, 1);
        chk("resp_first_byte", resp_data, w[7:0]);
        chk("send_state", debug_state, 3);
    endtask

    // mode 0: resp_ready toggles every cycle; mode 1: random
    task automatic recv_rsp(input logic [127:0] exp, input int mode);
        int  k = 0;
        int  n = 0;
        bit  rr = 1'b1;
        while (k < 16 && n < 400) begin
            resp_ready = (mode == 0) ? rr : 1'($urandom_range(0, 1));
            rr = ~rr;
            @(negedge clk);
            if (resp_valid && resp_ready) begin
                chk($sformatf("resp_byte%0d", k), resp_data, exp[8*k +: 8]);
                chk("busy_during_send", busy, 1);
                k++;
            end
            tick();
            n++;
        end
        resp_ready = 1'b0;
        chk("resp_count", k, 16);
        chk("collect_reentry", debug_state, 0);
        chk("collect_in_ready", in_ready, 1);
        chk("busy_after_send", busy, 0);
    endtask

    initial begin
        logic [127:0] pkt, rsp;
        reset = 1'b0; in_valid = 1'b0; in_data = 8'h00; req_ready = 1'b0;
        rsp_valid = 1'b0; rsp_bits = '0; resp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("rst");
        @(negedge clk) reset = 1'b1;
        tick();

        // Incrementing bytes back-to-back, request stalled for 5 cycles
        pkt = 128'h0F0E0D0C0B0A09080706050403020100;
        send_bytes(pkt, 16, 0, 1);
        issue_ack(pkt, 5, 1);
        rsp = 128'hFFEEDDCCBBAA99887766554433221100;
        give_rsp(rsp, 2);
        recv_rsp(rsp, 0);

        // Watchdog behaviour with no response
        pkt = {$urandom, $urandom, $urandom, $urandom};
        send_bytes(pkt, 16, 0, 1);
        issue_ack(pkt, 0, 0);
`ifdef STL_BRIDGE_TIMEOUT_EN
        begin
            int n = 0;
            while (!resp_valid && n < 1000) begin
                tick();
                n++;
            end
            chk("tmo_resp_valid", resp_valid, 1);
            recv_rsp({16{8'hEE}}, 0);
            chk("tmo_count", timeout_count, 1);
        end
`else
        begin
            bit stayed = 1'b1;
            for (int i = 0; i < 10000; i++) begin
                tick();
                if (debug_state != 2'd2 || resp_valid) stayed = 1'b0;
            end
            chk("wait_forever", stayed, 1);
            chk("tmo_count_tied", timeout_count, 0);
            rsp = {$urandom, $urandom, $urandom, $urandom};
            give_rsp(rsp, 0);
            recv_rsp(rsp, 1);
        end
`endif

        // Reset mid-packet, then a clean packet
        pkt = {$urandom, $urandom, $urandom, $urandom};
        send_bytes(pkt, 7, 0, 0);
        chk("busy_partial", busy, 1);
        reset = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        @(negedge clk) reset = 1'b1;
        tick();
        pkt = 128'hAFAEADACABAAA9A8A7A6A5A4A3A2A1A0;
        send_bytes(pkt, 16, 0, 1);
        issue_ack(pkt, 1, 0);
        rsp = {$urandom, $urandom, $urandom, $urandom};
        give_rsp(rsp, 1);
        recv_rsp(rsp, 0);

        // Two randomized round trips with input gaps
        for (int t = 0; t < 2; t++) begin
            pkt = {$urandom, $urandom, $urandom, $urandom};
            rsp = {$urandom, $urandom, $urandom, $urandom};
            send_bytes(pkt, 16, 3, 1);
            issue_ack(pkt, $urandom_range(0, 4), 0);
            give_rsp(rsp, $urandom_range(0, 6));
            recv_rsp(rsp, 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
